// File: rtl/seg7_display_mux_if.sv
// seg7_display_mux_if: source words and controls in, segment frame and commit pulse out.
interface seg7_display_mux_if #(
   parameter int NUM_SRC    = 4,
   parameter int NUM_FIELDS = 3,
   parameter int FIELD_W    = 8
);
   localparam int SEL_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
   logic [NUM_SRC*NUM_FIELDS*FIELD_W-1:0] src_data;
   logic [SEL_W-1:0]                      src_sel;
   logic [NUM_FIELDS-1:0]                 blink_mask;
   logic                                  blank_lead;
   logic [NUM_FIELDS*14-1:0]              seg_out;
   logic                                  frame_done;
   modport master (output src_data, src_sel, blink_mask, blank_lead, input seg_out, frame_done);
   modport slave (input src_data, src_sel, blink_mask, blank_lead, output seg_out, frame_done);
endinterface

// File: rtl/seg7_display_mux.sv
// seg7_display_mux: snapshots a selected source word, converts every field to BCD with a
// shift-add-3 engine and commits all seven-segment digits atomically once per frame.
module seg7_display_mux #(
   parameter int NUM_SRC    = 4,
   parameter int NUM_FIELDS = 3,
   parameter int FIELD_W    = 8,
   parameter int BLINK_DIV  = 25000000,
   parameter int ACTIVE_LOW = 1
) (
   input logic clock_i,
   input logic reset_i,
   seg7_display_mux_if.slave bus
);
   localparam int SEL_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
   localparam int CNT_W = $clog2(FIELD_W);
   localparam int BLK_W = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   localparam logic [1:0] S_LOAD = 2'd0, S_SHIFT = 2'd1, S_COMMIT = 2'd2;
   localparam logic [6:0] BLANK = ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
   localparam logic [6:0] DASH = ACTIVE_LOW != 0 ? 7'h3F : 7'h40;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] pol(input logic [6:0] p);
      return ACTIVE_LOW != 0 ? ~p : p;
   endfunction

   logic [1:0]                          state_q, state_d;
   logic [CNT_W-1:0]                    bit_q, bit_d;
   logic [NUM_FIELDS-1:0][FIELD_W-1:0]  bin_q, bin_d;
   logic [NUM_FIELDS-1:0][3:0]          ones_q, ones_d, tens_q, tens_d, ones_a, tens_a;
   logic [NUM_FIELDS-1:0]               ovf_q, ovf_d;
   logic                                inv_q, inv_d;
   logic [BLK_W-1:0]                    blk_q, blk_d;
   logic                                phase_q, phase_d;
   logic [NUM_FIELDS*14-1:0]            seg_q, seg_d;
   logic                                done_q, done_d;
   logic [NUM_FIELDS-1:0][13:0]         enc;
   logic                                inv_w;
   logic [SEL_W-1:0]                    sel_v;

   assign inv_w = int'(bus.src_sel) >= NUM_SRC;
   assign sel_v = inv_w ? '0 : bus.src_sel;

   // A carry out of the tens nibble means hundreds != 0; it is kept sticky as ovf.
   always_comb begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
         ones_a[f] = ones_q[f] >= 4'd5 ? ones_q[f] + 4'd3 : ones_q[f];
         tens_a[f] = tens_q[f] >= 4'd5 ? tens_q[f] + 4'd3 : tens_q[f];
         enc[f][13:7] = (inv_q || ovf_q[f]) ? DASH :
                        (bus.blink_mask[f] && phase_q) ? BLANK :
                        (bus.blank_lead && tens_q[f] == 4'd0) ? BLANK : pol(dec7(tens_q[f]));
         enc[f][6:0] = (inv_q || ovf_q[f]) ? DASH :
                       (bus.blink_mask[f] && phase_q) ? BLANK : pol(dec7(ones_q[f]));
      end
   end

   always_comb begin
      state_d = state_q;
      bit_d = bit_q;
      bin_d = bin_q;
      ones_d = ones_q;
      tens_d = tens_q;
      ovf_d = ovf_q;
      inv_d = inv_q;
      seg_d = seg_q;
      done_d = 1'b0;
      blk_d = blk_q == BLK_W'(BLINK_DIV - 1) ? '0 : blk_q + 1'b1;
      phase_d = blk_q == BLK_W'(BLINK_DIV - 1) ? ~phase_q : phase_q;
      case (state_q)
         S_LOAD: begin
            inv_d = inv_w;
            for (int f = 0; f < NUM_FIELDS; f++)
               bin_d[f] = bus.src_data[(int'(sel_v) * NUM_FIELDS + f) * FIELD_W +: FIELD_W];
            ones_d = '0;
            tens_d = '0;
            ovf_d = '0;
            bit_d = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            for (int f = 0; f < NUM_FIELDS; f++) begin
               ones_d[f] = {ones_a[f][2:0], bin_q[f][FIELD_W-1]};
               tens_d[f] = {tens_a[f][2:0], ones_a[f][3]};
               ovf_d[f] = ovf_q[f] | tens_a[f][3];
               bin_d[f] = bin_q[f] << 1;
            end
            bit_d = bit_q + 1'b1;
            state_d = bit_q == CNT_W'(FIELD_W - 1) ? S_COMMIT : S_SHIFT;
         end
         S_COMMIT: begin
            seg_d = enc;
            done_d = 1'b1;
            state_d = S_LOAD;
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= S_LOAD;
         bit_q <= '0;
         bin_q <= '0;
         ones_q <= '0;
         tens_q <= '0;
         ovf_q <= '0;
         inv_q <= 1'b0;
         blk_q <= '0;
         phase_q <= 1'b0;
         seg_q <= {NUM_FIELDS*2{BLANK}};
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q <= bit_d;
         bin_q <= bin_d;
         ones_q <= ones_d;
         tens_q <= tens_d;
         ovf_q <= ovf_d;
         inv_q <= inv_d;
         blk_q <= blk_d;
         phase_q <= phase_d;
         seg_q <= seg_d;
         done_q <= done_d;
      end
   end

   assign bus.seg_out = seg_q;
   assign bus.frame_done = done_q;
endmodule
